vga_plot_arbiter: RTL and testbench
===================================

# vga_plot_arbiter

Round-robin arbiter that shares the single VGA adapter write port (x, y, colour, plot) between several drawing clients: the animation player, board renderer, piece/cursor drawer and text overlay. A client requests the port, holds it for a complete region draw, and releases it with a done pulse. The block registers the winning client's pixel stream onto the adapter port and inserts a dead cycle between owners, so pixels from two clients are never interleaved.

## Interface
- NUM_REQ, 4: number of clients (2..8).
- TIMEOUT_CYCLES, 20000: maximum grant length when the watchdog is compiled in. The default is one full 160x120 frame plus margin.
- Clock  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  level request, one bit per client.
- done  in  NUM_REQ  one-cycle release pulse, one bit per client.
- x_in  in  8*NUM_REQ  packed client x coordinates; client i occupies [8i+7:8i].
- y_in  in  7*NUM_REQ  packed client y coordinates.
- color_in  in  3*NUM_REQ  packed client colours.
- plot_in  in  NUM_REQ  client write strobes.
- grant  out  NUM_REQ  one-hot ownership, registered.
- x  out  8  to the VGA adapter.
- y  out  7  to the VGA adapter.
- color  out  3  to the VGA adapter.
- plot  out  1  to the VGA adapter.
- busy  out  1  high while any grant is held.
- timeout  out  1  one-cycle pulse when the watchdog revokes a grant. Tied to 0 when the watchdog is compiled out.

## Operation
- States and transitions:
  - IDLE: no owner.
  - ACTIVE: one client owns the port.
  - RELEASE: one dead cycle.
  - IDLE -> ACTIVE when any req bit is high.
  - ACTIVE -> RELEASE on done[owner], on req[owner] falling, or on watchdog expiry.
  - RELEASE -> IDLE unconditionally.
- Arbitration: rotating priority. The search starts at ptr; the first index i with req[i]=1 wins. On grant, ptr <= (winner+1) mod NUM_REQ.
- done and plot_in from non-owners are ignored. done[owner] has priority over plot_in[owner] in the same cycle: that pixel is still forwarded, then the grant releases.
- Output mux: in ACTIVE, x/y/color/plot are registered copies of the owner's slice. In IDLE and RELEASE, plot=0 and x/y/color hold their last values.
- A requester that holds req continuously is served again only after every other active requester has had one grant.
- Reset values: state=IDLE, ptr=0, grant=0, busy=0, plot=0, x=0, y=0, color=0, timeout=0, watchdog counter=0.
- Reset asserted mid-grant: all of the above apply on the next edge. The in-flight draw is abandoned, and no pixel is emitted in the reset cycle.

## Timing
- Edge n, req sampled in IDLE: grant and busy go high at edge n+1.
- A client may drive plot_in from the cycle it sees grant. plot/x/y/color appear on the adapter one cycle later, giving a fixed 1-cycle pipeline latency.
- Clients with a 1-cycle ROM read (address from counters, data next cycle) must delay their own x/y by one cycle to match colour. The arbiter adds no compensation.
- Edge m, done[owner] sampled: grant=0 at m+1 (RELEASE), IDLE at m+2. The earliest next grant is at m+3.
- Minimum gap between two owners' forwarded pixels: 2 cycles.
- busy falls in the same cycle as grant.

## Configuration
- VGA_ARB_WATCHDOG_EN defined:
  - A 15-bit counter clears on entry to ACTIVE and increments each cycle in ACTIVE.
  - When it reaches TIMEOUT_CYCLES-1, the arbiter goes to RELEASE and pulses timeout for one cycle, coincident with grant falling.
  - ptr advances normally.
- Not defined: no counter is built, timeout is constant 0, and the grant is held until done or the owner's req falls.

## Structure
- Shared package vga_pkg:
  - constants SCREEN_W=160, SCREEN_H=120, X_W=8, Y_W=7, COLOR_W=3;
  - state enum ARB_IDLE/ARB_ACTIVE/ARB_RELEASE.
- One sub-module, rr_pick: combinational rotating-priority encoder that takes req and ptr and returns a one-hot winner plus a valid flag. It is reused by the planned sound-channel scheduler.
- Everything else lives in vga_plot_arbiter: the state register, ptr, the output registers and the watchdog.

## Test plan
- Single client: req[1]=1 at cycle 10 -> grant=4'b0010 at 11. Client plots (x=30,y=0,c=3'b111) at 11 -> adapter plot=1, x=30, y=0, color=7 at 12. done at 20 -> grant=0 at 21, IDLE at 22.
- Fairness: req=4'b1111 held, each client pulses done 5 cycles after its grant -> grant order 0,1,2,3,0 with ptr wrapping, and a 2-cycle gap between owners.
- Isolation: owner 2 is granted while client 0 drives plot_in=1 and done=1 -> adapter shows only client 2's pixels, and client 0's done has no effect.
- Owner abandons: req[3] falls at cycle 50 with no done -> RELEASE at 51, and the waiting req[0] is granted at 53.
- Reset mid-draw: resetn=0 during ACTIVE -> next edge grant=0, plot=0, x=y=color=0, ptr=0. After reset, with req=4'b1010, client 1 wins.
- Watchdog (VGA_ARB_WATCHDOG_EN, TIMEOUT_CYCLES=16): owner never sends done -> timeout pulses and grant falls exactly 16 cycles after grant rose. Without the macro, the grant is still held after 100 cycles.

Source files
------------

// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA drawing blocks.
//   SCREEN_W / SCREEN_H : visible resolution of the 160x120 adapter
//   X_W / Y_W / COLOR_W : widths of the adapter x, y and colour buses
//   arb_state_t         : plot-port arbiter state encoding
// ----------------------------------------------------------------------------
package vga_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOR_W  = 3;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_ACTIVE  = 2'd1,
      ARB_RELEASE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// ----------------------------------------------------------------------------
// vga_plot_arbiter_if
// Bundle between the drawing clients and the plot-port arbiter.
//   Client side : req, done, x_in, y_in, color_in, plot_in (packed per client)
//   Arbiter side: grant, busy, timeout and the adapter bus x, y, color, plot
// Modports: slave = the arbiter, master = the clients / adapter.
//
// Handshake: req is a level held by a client for the whole region draw.
// grant is one-hot and registered; a client owns the port from the first
// cycle it sees its grant bit until it pulses done (one cycle) or drops req.
// plot_in from the owner is forwarded to plot one cycle later; plot_in and
// done from non-owners are ignored.
// ----------------------------------------------------------------------------
interface vga_plot_arbiter_if #(
   parameter int NUM_REQ = 4
);
   import vga_pkg::*;

   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ-1:0]         done;
   logic [X_W*NUM_REQ-1:0]     x_in;
   logic [Y_W*NUM_REQ-1:0]     y_in;
   logic [COLOR_W*NUM_REQ-1:0] color_in;
   logic [NUM_REQ-1:0]         plot_in;

   logic [NUM_REQ-1:0]         grant;
   logic [X_W-1:0]             x;
   logic [Y_W-1:0]             y;
   logic [COLOR_W-1:0]         color;
   logic                       plot;
   logic                       busy;
   logic                       timeout;

   modport slave (
      input  req, done, x_in, y_in, color_in, plot_in,
      output grant, x, y, color, plot, busy, timeout
   );

   modport master (
      output req, done, x_in, y_in, color_in, plot_in,
      input  grant, x, y, color, plot, busy, timeout
   );

endinterface

// File: rtl/vga_plot_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority encoder. The search starts at ptr_i and
// wraps; the first set request bit wins.
//   req_i   : request vector
//   ptr_i   : index with highest priority (must be < N)
//   gnt_o   : one-hot winner (all zero when no request)
//   valid_o : at least one request present
// ----------------------------------------------------------------------------
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic          valid_o
);

   logic [PW:0]   sum;
   logic [PW-1:0] idx;

   always_comb begin
      gnt_o   = '0;
      valid_o = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         // one extra bit so ptr + k cannot overflow before the wrap
         sum = {1'b0, ptr_i} + (PW+1)'(k);
         if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
         idx = sum[PW-1:0];
         if (!valid_o && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            valid_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_plot_arbiter.sv
// ----------------------------------------------------------------------------
// vga_plot_arbiter
// Round-robin owner of the single VGA adapter write port. A client holds the
// port for a whole region draw; the owner's pixel stream is registered onto
// the adapter bus and a dead RELEASE cycle separates consecutive owners.
//   Clock, resetn : clock, synchronous active-low reset
//   bus (slave)   : client requests/pixels in, grant/busy/timeout and the
//                   adapter x/y/color/plot out
//   dbg_state_o   : current arbiter state
//   dbg_ptr_o     : current round-robin pointer
// Optional feature: define VGA_ARB_WATCHDOG_EN to build a grant-length
// watchdog that revokes a grant after TIMEOUT_CYCLES cycles.
// ----------------------------------------------------------------------------
module vga_plot_arbiter
   import vga_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 20000,
   parameter int PW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 Clock,
   input  logic                 resetn,
   vga_plot_arbiter_if.slave    bus,
   output arb_state_t           dbg_state_o,
   output logic [PW-1:0]        dbg_ptr_o
);

   arb_state_t         state_q;
   logic [PW-1:0]      ptr_q;
   logic [PW-1:0]      owner_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [X_W-1:0]     x_q;
   logic [Y_W-1:0]     y_q;
   logic [COLOR_W-1:0] color_q;
   logic               plot_q;
   logic               timeout_q;

   logic [NUM_REQ-1:0] pick_gnt;
   logic               pick_valid;
   logic [PW-1:0]      win_idx;
   logic [PW-1:0]      ptr_d;

   logic [X_W-1:0]     sel_x;
   logic [Y_W-1:0]     sel_y;
   logic [COLOR_W-1:0] sel_color;
   logic               own_plot;
   logic               own_done;
   logic               own_req;
   logic               wd_expire;

   rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
      .req_i   (bus.req),
      .ptr_i   (ptr_q),
      .gnt_o   (pick_gnt),
      .valid_o (pick_valid)
   );

   // one-hot winner to index, and the pointer that follows it
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_gnt[i]) win_idx = PW'(i);
      end
      ptr_d = (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
   end

   // owner's slice of the packed client buses
   always_comb begin
      sel_x     = '0;
      sel_y     = '0;
      sel_color = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == PW'(i)) begin
            sel_x     = bus.x_in[i*X_W +: X_W];
            sel_y     = bus.y_in[i*Y_W +: Y_W];
            sel_color = bus.color_in[i*COLOR_W +: COLOR_W];
         end
      end
      own_plot = bus.plot_in[owner_q];
      own_done = bus.done[owner_q];
      own_req  = bus.req[owner_q];
   end

`ifdef VGA_ARB_WATCHDOG_EN
   logic [14:0] wd_cnt_q;

   // held at zero outside ACTIVE, so it starts from zero on every new grant
   always_ff @(posedge Clock) begin
      if (!resetn)                   wd_cnt_q <= '0;
      else if (state_q != ARB_ACTIVE) wd_cnt_q <= '0;
      else                           wd_cnt_q <= wd_cnt_q + 15'd1;
   end

   assign wd_expire = (state_q == ARB_ACTIVE) && (wd_cnt_q == 15'(TIMEOUT_CYCLES-1));
`else
   // no watchdog: never expires (TIMEOUT_CYCLES only matters when it is built)
   assign wd_expire = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

   always_ff @(posedge Clock) begin
      if (!resetn) begin
         state_q   <= ARB_IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         grant_q   <= '0;
         x_q       <= '0;
         y_q       <= '0;
         color_q   <= '0;
         plot_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         plot_q    <= 1'b0;
         timeout_q <= 1'b0;
         case (state_q)
            ARB_IDLE: begin
               if (pick_valid) begin
                  state_q <= ARB_ACTIVE;
                  grant_q <= pick_gnt;
                  owner_q <= win_idx;
                  ptr_q   <= ptr_d;
               end
            end
            ARB_ACTIVE: begin
               // the owner's pixel is forwarded even in its release cycle
               x_q     <= sel_x;
               y_q     <= sel_y;
               color_q <= sel_color;
               plot_q  <= own_plot;
               if (own_done || !own_req || wd_expire) begin
                  state_q   <= ARB_RELEASE;
                  grant_q   <= '0;
                  // a normal release in the expiry cycle is not a revocation
                  timeout_q <= wd_expire && !own_done && own_req;
               end
            end
            ARB_RELEASE: state_q <= ARB_IDLE;
            default:     state_q <= ARB_IDLE;
         endcase
      end
   end

   assign bus.grant   = grant_q;
   assign bus.busy    = |grant_q;
   assign bus.x       = x_q;
   assign bus.y       = y_q;
   assign bus.color   = color_q;
   assign bus.plot    = plot_q;
   assign bus.timeout = timeout_q;
   assign dbg_state_o = state_q;
   assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vga_plot_arbiter
// Directed bench for vga_plot_arbiter (4 clients, TIMEOUT_CYCLES=16).
// Expected pixels and grant values are queued as stimulus is issued; a
// monitor on the falling edge pops and compares whenever the DUT shows a
// pixel or a new grant. Cycle-exact timing is checked inline.
// ----------------------------------------------------------------------------
module tb_vga_plot_arbiter;
   import vga_pkg::*;

   localparam int N = 4;

   logic       Clock;
   logic       resetn;
   arb_state_t dbg_state;
   logic [1:0] dbg_ptr;

   vga_plot_arbiter_if #(.NUM_REQ(N)) bus ();

   vga_plot_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
      .Clock       (Clock),
      .resetn      (resetn),
      .bus         (bus.slave),
      .dbg_state_o (dbg_state),
      .dbg_ptr_o   (dbg_ptr)
   );

   // ---------------- clock / reset ----------------
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // ---------------- scoreboard state ----------------
   logic [17:0] exp_q[$];   // {x, y, color}
   logic [3:0]  gnt_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [3:0]  prev_gnt = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic set_px(input int c, input logic [7:0] xx, input logic [6:0] yy, input logic [2:0] cc);
      bus.x_in[c*8 +: 8]     = xx;
      bus.y_in[c*7 +: 7]     = yy;
      bus.color_in[c*3 +: 3] = cc;
   endtask

   // one-cycle pixel from client c; queued only if c is expected to own the port
   task automatic send_px(input int c, input logic [7:0] xx, input logic [6:0] yy,
                          input logic [2:0] cc, input bit owner);
      set_px(c, xx, yy, cc);
      bus.plot_in[c] = 1'b1;
      if (owner) exp_q.push_back({xx, yy, cc});
      tick();
      bus.plot_in[c] = 1'b0;
   endtask

   task automatic wait_grant(output int n);
      n = 0;
      while (bus.grant == '0 && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) check("grant_wait_timeout", 32'(n), 32'd0);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge Clock);
         if (bus.plot === 1'b1) begin
            if (exp_q.size() == 0) check("stray_plot", 32'(bus.plot), 32'd0);
            else check("pixel", 32'({bus.x, bus.y, bus.color}), 32'(exp_q.pop_front()));
         end
         if (bus.grant !== prev_gnt && bus.grant !== 4'b0000 && !$isunknown(bus.grant)) begin
            if (gnt_q.size() == 0) check("stray_grant", 32'(bus.grant), 32'd0);
            else check("grant_order", 32'(bus.grant), 32'(gnt_q.pop_front()));
         end
         prev_gnt = bus.grant;
      end
   end

   // ---------------- stimulus ----------------
   int  n;
   int  o;
   bit  saw_to;

   initial begin
      resetn       = 1'b0;
      bus.req      = '0;
      bus.done     = '0;
      bus.plot_in  = '0;
      bus.x_in     = '0;
      bus.y_in     = '0;
      bus.color_in = '0;
      repeat (3) tick();

      // reset state
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_plot", 32'(bus.plot), 32'd0);
      check("rst_xyc", 32'({bus.x, bus.y, bus.color}), 32'd0);
      check("rst_timeout", 32'(bus.timeout), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
      check("rst_ptr", 32'(dbg_ptr), 32'd0);
      resetn = 1'b1;
      repeat (6) tick();

      // single client
      gnt_q.push_back(4'b0010);
      bus.req[1] = 1'b1;
      tick();
      check("single_grant", 32'(bus.grant), 32'h2);
      check("single_busy", 32'(bus.busy), 32'd1);
      send_px(1, 8'd30, 7'd0, 3'b111, 1'b1);
      check("single_pix_plot", 32'(bus.plot), 32'd1);
      check("single_pix_x", 32'(bus.x), 32'd30);
      repeat (7) tick();
      bus.done[1] = 1'b1;
      tick();
      bus.done[1] = 1'b0;
      bus.req[1]  = 1'b0;
      check("single_rel_grant", 32'(bus.grant), 32'd0);
      check("single_rel_busy", 32'(bus.busy), 32'd0);
      check("single_rel_state", 32'(dbg_state), 32'(ARB_RELEASE));
      check("single_rel_plot", 32'(bus.plot), 32'd0);
      tick();
      check("single_idle", 32'(dbg_state), 32'(ARB_IDLE));
      tick();

      // fairness from ptr=0
      do_reset();
      check("fair_ptr0", 32'(dbg_ptr), 32'd0);
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         o = k % 4;
         gnt_q.push_back(4'b0001 << o);
         wait_grant(n);
         if (k > 0) check("fair_gap", 32'(n), 32'd2);
         send_px(o, 8'(10*o + 1), 7'(o), 3'(o), 1'b1);
         repeat (3) tick();
         bus.done[o] = 1'b1;
         tick();
         bus.done[o] = 1'b0;
      end
      bus.req = '0;
      tick();
      tick();
      check("fair_ptr_end", 32'(dbg_ptr), 32'd1);

      // isolation: owner 2, client 0 plots and pulses done without owning
      gnt_q.push_back(4'b0100);
      bus.req = 4'b0100;
      wait_grant(n);
      for (int j = 0; j < 3; j++) begin
         set_px(0, 8'd99, 7'd1, 3'd1);
         set_px(2, 8'(20 + j), 7'(40 + j), 3'd6);
         bus.plot_in = 4'b0101;
         bus.done[0] = 1'b1;
         exp_q.push_back({8'(20 + j), 7'(40 + j), 3'd6});
         tick();
      end
      bus.plot_in = '0;
      bus.done    = '0;
      check("iso_hold", 32'(bus.grant), 32'h4);
      set_px(2, 8'd159, 7'd119, 3'd5);
      bus.plot_in[2] = 1'b1;
      bus.done[2]    = 1'b1;
      exp_q.push_back({8'd159, 7'd119, 3'd5});
      tick();
      bus.plot_in = '0;
      bus.done    = '0;
      bus.req     = '0;
      check("iso_rel_grant", 32'(bus.grant), 32'd0);
      check("iso_rel_state", 32'(dbg_state), 32'(ARB_RELEASE));
      tick();
      check("iso_idle", 32'(dbg_state), 32'(ARB_IDLE));
      tick();

      // owner abandons: 3 drops req, waiting 0 is served
      gnt_q.push_back(4'b1000);
      gnt_q.push_back(4'b0001);
      bus.req = 4'b1001;
      wait_grant(n);
      check("aband_grant3", 32'(bus.grant), 32'h8);
      tick();
      bus.req[3] = 1'b0;
      tick();
      check("aband_rel", 32'(dbg_state), 32'(ARB_RELEASE));
      check("aband_rel_grant", 32'(bus.grant), 32'd0);
      tick();
      check("aband_gap", 32'(bus.grant), 32'd0);
      tick();
      check("aband_grant0", 32'(bus.grant), 32'h1);

      // reset in the middle of owner 0's draw
      send_px(0, 8'd55, 7'd44, 3'd5, 1'b1);
      set_px(0, 8'd77, 7'd33, 3'd2);
      bus.plot_in[0] = 1'b1;
      resetn = 1'b0;
      tick();
      bus.plot_in = '0;
      check("mid_rst_grant", 32'(bus.grant), 32'd0);
      check("mid_rst_plot", 32'(bus.plot), 32'd0);
      check("mid_rst_xyc", 32'({bus.x, bus.y, bus.color}), 32'd0);
      check("mid_rst_ptr", 32'(dbg_ptr), 32'd0);
      check("mid_rst_state", 32'(dbg_state), 32'(ARB_IDLE));
      gnt_q.push_back(4'b0010);
      bus.req = 4'b1010;
      resetn  = 1'b1;
      tick();
      check("post_rst_grant", 32'(bus.grant), 32'h2);
      bus.done[1] = 1'b1;
      tick();
      bus.done = '0;
      bus.req  = '0;
      tick();
      tick();

      // watchdog: owner 2 never sends done
      gnt_q.push_back(4'b0100);
      bus.req = 4'b0100;
      wait_grant(n);
      saw_to = 1'b0;
`ifdef VGA_ARB_WATCHDOG_EN
      n = 0;
      while (bus.grant != '0 && n < 200) begin
         tick();
         n++;
         if (bus.grant == '0) saw_to = bus.timeout;
      end
      check("wd_length", 32'(n), 32'd16);
      check("wd_timeout_pulse", 32'(saw_to), 32'd1);
      tick();
      check("wd_timeout_low", 32'(bus.timeout), 32'd0);
`else
      for (int k = 0; k < 100; k++) begin
         tick();
         if (bus.timeout === 1'b1) saw_to = 1'b1;
      end
      check("nowd_hold", 32'(bus.grant), 32'h4);
      check("nowd_timeout", 32'(saw_to), 32'd0);
`endif
      bus.req = '0;
      repeat (4) tick();

      check("pix_queue_empty", 32'(exp_q.size()), 32'd0);
      check("gnt_queue_empty", 32'(gnt_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
